// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the fifo_wr_arb write arbiter.
// Holds the packet-lock state enum and the round-robin pick function.
package fifo_wr_arb_pkg;

    // Widest supported requester count and its index width.
    localparam int MAX_N  = 16;
    localparam int MAX_TW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              found;
        logic [MAX_TW-1:0] idx;
    } pick_t;

    // First set bit of valid, searching from ptr upward and wrapping n-1 -> 0.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0]  valid,
                                      input logic [MAX_TW-1:0] ptr,
                                      input int                n);
        pick_t             r;
        int                pos;
        logic [MAX_TW-1:0] pos_idx;
        r = '0;
        for (int k = 0; k < MAX_N; k++) begin
            pos     = (int'(ptr) + k) % n;
            pos_idx = pos[MAX_TW-1:0];
            if ((k < n) && !r.found && valid[pos_idx]) begin
                r.found = 1'b1;
                r.idx   = pos_idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority rotate with its registered search pointer.
// The pointer moves to grant+1 (mod N) only when upd is asserted.
module rr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int TW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  valid,
    input  logic          upd,
    output logic [TW-1:0] grant,
    output logic          found
);

    logic [TW-1:0]     rr_reg;
    logic [MAX_N-1:0]  valid_w;
    logic [MAX_TW-1:0] ptr_w;
    pick_t             pick;

    // Widen to the package function's fixed width and search from rr_reg.
    always_comb begin
        valid_w          = '0;
        valid_w[N-1:0]   = valid;
        ptr_w            = '0;
        ptr_w[TW-1:0]    = rr_reg;
        pick             = rr_pick(valid_w, ptr_w, N);
        grant            = pick.idx[TW-1:0];
        found            = pick.found;
    end

    // Pointer register: restart at requester 0, advance past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg <= '0;
        end else if (upd) begin
            if (grant == TW'(N - 1))
                rr_reg <= '0;
            else
                rr_reg <= grant + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding one FIFO write port from N producers.
// A one-word output stage registers {tag, data} and drains when not full.
// Optional packet lock: define FIFO_WR_ARB_LOCK_EN to keep a grant on one
// requester until it presents s_last.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int B  = 16,
    localparam int TW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_valid,
    output logic [N-1:0]    s_ready,
    input  logic [N*B-1:0]  s_data,
    input  logic [N-1:0]    s_last,
    output logic            fifo_wr_en,
    output logic [TW+B-1:0] fifo_din,
    input  logic            fifo_full,
    output logic            busy
);

    logic          ov_reg;
    logic [B-1:0]  od_reg;
    logic [TW-1:0] ot_reg;
    logic          ld;
    logic          accept;
    logic          locked;
    logic          rr_upd;
    logic          found;
    logic [TW-1:0] grant;
    logic [N-1:0]  valid_m;

    assign fifo_wr_en = ov_reg & ~fifo_full;
    assign fifo_din   = {ot_reg, od_reg};
    // Stage can take a word when empty or when its word leaves this cycle.
    assign ld         = ~ov_reg | fifo_wr_en;
    assign accept     = ld & found & ~rst;
    assign busy       = ov_reg | locked;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign s_ready[gi] = accept & (grant == TW'(gi));
        end
    endgenerate

    rr_arbiter #(.N(N)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .valid (valid_m),
        .upd   (rr_upd),
        .grant (grant),
        .found (found)
    );

`ifdef FIFO_WR_ARB_LOCK_EN
    arb_state_t    state_reg, state_next;
    logic [TW-1:0] lock_idx_reg, lock_idx_next;

    // While locked, only the owning requester is visible to the arbiter.
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign valid_m[gi] = s_valid[gi] &
                                 ((state_reg == IDLE) | (lock_idx_reg == TW'(gi)));
        end
    endgenerate

    assign locked = (state_reg == LOCK);

    // Lock state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            lock_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            lock_idx_reg <= lock_idx_next;
        end
    end

    // Enter/stay locked on a non-final word; release and rotate on s_last.
    always_comb begin
        state_next    = state_reg;
        lock_idx_next = lock_idx_reg;
        rr_upd        = 1'b0;
        if (accept) begin
            if (s_last[grant]) begin
                state_next = IDLE;
                rr_upd     = 1'b1;
            end else begin
                state_next    = LOCK;
                lock_idx_next = grant;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^s_last;
    assign valid_m     = s_valid;
    assign locked      = 1'b0;
    assign rr_upd      = accept;
`endif

    // Output stage: load on accept, otherwise clear once the word drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_reg <= 1'b0;
            od_reg <= '0;
            ot_reg <= '0;
        end else if (accept) begin
            ov_reg <= 1'b1;
            od_reg <= s_data[int'(grant)*B +: B];
            ot_reg <= grant;
        end else begin
            ov_reg <= ov_reg & ~fifo_wr_en;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb (N=4 main instance, N=3 wrap instance).
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int B  = 16;
    localparam int TW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_valid, s_ready, s_last;
    logic [N*B-1:0]  s_data;
    logic            fifo_wr_en, fifo_full, busy;
    logic [TW+B-1:0] fifo_din;

    logic [2:0]      v3, r3, l3;
    logic [47:0]     d3;
    logic            we3, full3, busy3;
    logic [17:0]     din3;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fifo_wr_arb #(.N(N), .B(B)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .fifo_full(fifo_full), .busy(busy)
    );

    fifo_wr_arb #(.N(3), .B(16)) u_dut3 (
        .clk(clk), .rst(rst), .s_valid(v3), .s_ready(r3),
        .s_data(d3), .s_last(l3), .fifo_wr_en(we3),
        .fifo_din(din3), .fifo_full(full3), .busy(busy3)
    );

    // One line per FIFO write on the main instance.
    always @(posedge clk) begin
        if (!rst && fifo_wr_en)
            $display("write tag=%0d data=%h", fifo_din[TW+B-1:B], fifo_din[B-1:0]);
    end

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++; if (s_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", s_ready); else passes++;
            checks++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
            checks++; if (fifo_din !== '0) $display("FAIL reset_din: got %h expected 0", fifo_din); else passes++;
        end
        @(negedge clk); rst = 1'b0; s_valid = '0; #1;
        checks++; if (s_ready !== 4'b0000) $display("FAIL idle_ready: got %b expected 0000", s_ready); else passes++;
    endtask

    task automatic test_round_robin;
        logic [TW+B-1:0] e;
        int p;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); s_valid = 4'hF; #1;
            checks++; if (s_ready !== 4'(1 << (k % 4))) $display("FAIL rr_ready[%0d]: got %b expected %b", k, s_ready, 4'(1 << (k % 4))); else passes++;
            if (k == 0) begin
                checks++; if (fifo_wr_en !== 1'b0) $display("FAIL rr_first_wr_en: got %b expected 0", fifo_wr_en); else passes++;
            end else begin
                p = (k + 3) % 4;
                e = {TW'(p), B'(16'h00A0 + p)};
                checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== e) $display("FAIL rr_write[%0d]: got en=%b din=%h expected en=1 din=%h", k, fifo_wr_en, fifo_din, e); else passes++;
            end
        end
        @(negedge clk); s_valid = '0; #1;
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== {2'd3, 16'h00A3}) $display("FAIL rr_drain: got en=%b din=%h expected en=1 din=300a3", fifo_wr_en, fifo_din); else passes++;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) $display("FAIL rr_idle: got busy=%b en=%b expected 0 0", busy, fifo_wr_en); else passes++;
    endtask

    task automatic test_full;
        @(negedge clk); s_data[2*B +: B] = 16'h1234; s_valid = 4'b0100; #1;
        checks++; if (s_ready !== 4'b0100) $display("FAIL full_load_ready: got %b expected 0100", s_ready); else passes++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); s_valid = 4'hF; fifo_full = 1'b1; #1;
            checks++; if (fifo_wr_en !== 1'b0) $display("FAIL full_wr_en[%0d]: got %b expected 0", c, fifo_wr_en); else passes++;
            checks++; if (s_ready !== 4'b0000) $display("FAIL full_ready[%0d]: got %b expected 0000", c, s_ready); else passes++;
            checks++; if (fifo_din !== {2'd2, 16'h1234} || busy !== 1'b1) $display("FAIL full_hold[%0d]: got din=%h busy=%b expected 21234 1", c, fifo_din, busy); else passes++;
        end
        @(negedge clk); fifo_full = 1'b0; #1;
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== {2'd2, 16'h1234}) $display("FAIL full_release_write: got en=%b din=%h expected en=1 din=21234", fifo_wr_en, fifo_din); else passes++;
        checks++; if (s_ready !== 4'b1000) $display("FAIL full_release_ready: got %b expected 1000", s_ready); else passes++;
        @(negedge clk); s_valid = '0; #1;
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== {2'd3, 16'h00A3}) $display("FAIL full_next_write: got en=%b din=%h expected en=1 din=300a3", fifo_wr_en, fifo_din); else passes++;
        @(negedge clk); s_data[2*B +: B] = 16'h00A2; #1;
        checks++; if (busy !== 1'b0) $display("FAIL full_idle: got busy=%b expected 0", busy); else passes++;
    endtask

    task automatic test_sparse;
        logic [N-1:0]    er [3];
        logic [TW+B-1:0] ed [3];
        er = '{4'b1000, 4'b0010, 4'b1000};
        ed = '{{2'd1, 16'h00A1}, {2'd3, 16'h00A3}, {2'd1, 16'h00A1}};
        @(negedge clk); s_valid = 4'b0010; #1;
        checks++; if (s_ready !== 4'b0010) $display("FAIL sparse_setup: got %b expected 0010", s_ready); else passes++;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); s_valid = 4'b1010; #1;
            checks++; if (s_ready !== er[j]) $display("FAIL sparse_ready[%0d]: got %b expected %b", j, s_ready, er[j]); else passes++;
            checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== ed[j]) $display("FAIL sparse_write[%0d]: got en=%b din=%h expected en=1 din=%h", j, fifo_wr_en, fifo_din, ed[j]); else passes++;
        end
        @(negedge clk); s_valid = '0; #1;
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== {2'd3, 16'h00A3}) $display("FAIL sparse_drain: got en=%b din=%h expected en=1 din=300a3", fifo_wr_en, fifo_din); else passes++;
        @(negedge clk); #1;
    endtask

    task automatic test_wrap3;
        logic [17:0] e;
        int p;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); v3 = 3'b111; #1;
            checks++; if (r3 !== 3'(1 << (j % 3))) $display("FAIL wrap3_ready[%0d]: got %b expected %b", j, r3, 3'(1 << (j % 3))); else passes++;
            if (j > 0) begin
                p = (j - 1) % 3;
                e = {2'(p), 16'(16'h0030 + p)};
                checks++; if (we3 !== 1'b1 || din3 !== e) $display("FAIL wrap3_write[%0d]: got en=%b din=%h expected en=1 din=%h", j, we3, din3, e); else passes++;
            end
        end
        @(negedge clk); v3 = '0; #1;
        @(negedge clk); #1;
        checks++; if (busy3 !== 1'b0) $display("FAIL wrap3_idle: got busy=%b expected 0", busy3); else passes++;
    endtask

    task automatic test_lock;
        int              g_exp [4];
        int              w;
        logic [TW+B-1:0] prev;
`ifdef FIFO_WR_ARB_LOCK_EN
        g_exp = '{1, 1, 1, 0};
`else
        g_exp = '{1, 0, 1, 0};
`endif
        @(negedge clk); s_valid = 4'b0001; s_last = 4'b0001; s_data[0 +: B] = 16'h00B0; #1;
        checks++; if (s_ready !== 4'b0001) $display("FAIL lock_setup: got %b expected 0001", s_ready); else passes++;
        w    = 0;
        prev = {2'd0, 16'h00B0};
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            s_valid = 4'b0011;
            s_last  = {2'b00, (w == 2), 1'b1};
            s_data[B +: B] = 16'h1100 + 16'(w);
            #1;
            checks++; if (s_ready !== 4'(1 << g_exp[j])) $display("FAIL lock_ready[%0d]: got %b expected %b", j, s_ready, 4'(1 << g_exp[j])); else passes++;
            checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== prev) $display("FAIL lock_write[%0d]: got en=%b din=%h expected en=1 din=%h", j, fifo_wr_en, fifo_din, prev); else passes++;
            if (g_exp[j] == 1) begin
                prev = {2'd1, 16'h1100 + 16'(w)};
                w++;
            end else begin
                prev = {2'd0, 16'h00B0};
            end
        end
        @(negedge clk); s_valid = '0; #1;
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== prev) $display("FAIL lock_drain: got en=%b din=%h expected en=1 din=%h", fifo_wr_en, fifo_din, prev); else passes++;
        @(negedge clk); #1;
    endtask

    task automatic test_reset_mid_packet;
        @(negedge clk); s_valid = 4'b0100; s_last = 4'b0000; s_data[2*B +: B] = 16'h00A2; #1;
        checks++; if (s_ready !== 4'b0100) $display("FAIL midrst_load: got %b expected 0100", s_ready); else passes++;
        @(negedge clk); rst = 1'b1; s_valid = 4'hF; #1;
        checks++; if (s_ready !== 4'b0000) $display("FAIL midrst_ready_in_reset: got %b expected 0000", s_ready); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy); else passes++;
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_din !== '0) $display("FAIL midrst_cleared: got busy=%b en=%b din=%h expected 0 0 0", busy, fifo_wr_en, fifo_din); else passes++;
        checks++; if (s_ready !== 4'b0001) $display("FAIL midrst_restart: got %b expected 0001", s_ready); else passes++;
        @(negedge clk); s_valid = '0; #1;
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 4'hF;
        s_last    = 4'hF;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) s_data[i*B +: B] = 16'h00A0 + 16'(i);
        v3    = '0;
        l3    = '1;
        full3 = 1'b0;
        for (int i = 0; i < 3; i++) d3[i*16 +: 16] = 16'h0030 + 16'(i);

        test_reset();
        test_round_robin();
        test_full();
        test_sparse();
        test_wrap3();
        test_lock();
        test_reset_mid_packet();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares the single write port of one `fifo_behav` instance among N independent producer streams. Each producer uses a valid/ready handshake. The arbiter picks one producer per cycle and registers its word plus a source tag into a one-word output stage. It then drives the FIFO `wr_en`/`din` from that stage, honouring `full`. It sits between several DSP/readout producers and a shared event/data FIFO.

## Interface
- `N`, 4: number of requesters; legal range 2..16.
- `B`, 16: payload width per requester.
- `TW`, derived as `$clog2(N)`: tag width (local parameter, not overridable).

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `s_valid`, in, N: bit i set means requester i offers a word.
- `s_ready`, out, N: bit i set means requester i's word is accepted this cycle. At most one bit is set per cycle.
- `s_data`, in, N*B: requester i's word sits at bits [i*B +: B].
- `s_last`, in, N: bit i marks the final word of a packet from requester i. Used only with `FIFO_WR_ARB_LOCK_EN`.
- `fifo_wr_en`, out, 1: write strobe to the FIFO.
- `fifo_din`, out, TW+B: word to the FIFO, packed as {tag, data}, with the tag in the MSBs.
- `fifo_full`, in, 1: FIFO full flag.
- `busy`, out, 1: high while the output stage holds a word or a lock is active.

## Operation
- Output stage registers: `ov` (valid), `od` (data), `ot` (tag).
- Drive rules:
  - `fifo_wr_en = ov & ~fifo_full`
  - `fifo_din = {ot, od}`
- Stage load condition, evaluated each cycle:
  - `ld = ~ov | fifo_wr_en`
  - A new word may enter in the same cycle the current word drains.
- Arbitration:
  - Search `s_valid` in round-robin order, starting at pointer `rr` (TW bits) and wrapping N-1 → 0.
  - The first set bit is the winner `g`.
  - `s_ready[g] = ld & |s_valid`. All other `s_ready` bits are 0.
  - `s_ready` never depends on `s_ready`, so there are no combinational loops; it does depend on `fifo_full`.
- On an accept (`s_valid[g] & s_ready[g]`):
  - `od <= s_data[g]`, `ot <= g`, `ov <= 1`.
  - `rr <= g+1` modulo N. When N is not a power of two, g = N-1 wraps to 0.
- When there is no accept, the stage clears only when it drains: `ov <= ov & ~fifo_wr_en`.
- `rr` holds when there is no accept.
- Fairness: a requester that holds `s_valid` high is granted within N accepts.
- Data is never dropped. While `fifo_full` is high, `ov` holds, `s_ready` is all zero, and `od`/`ot` are stable.
- `busy = ov | locked`.
- Reset, synchronous, including reset mid-transfer or mid-packet:
  - `ov = 0`, `od = 0`, `ot = 0`, `rr = 0`, `locked = 0`.
  - Outputs: `s_ready = 0`, `fifo_wr_en = 0`, `fifo_din = 0`, `busy = 0`.
  - Any word in flight is discarded.
  - During the reset cycle itself, `s_ready` is forced to 0.

## Timing
- Latency: a word accepted on edge k appears on `fifo_din` with `fifo_wr_en=1` in the cycle after k, if not full.
- Throughput: one word per cycle sustained while `fifo_full=0`.
- Backpressure from full is seen by requesters combinationally in the same cycle.
- Release after full: `fifo_full` falls in cycle c, so the held word is written in cycle c. A new accept can occur in that same cycle (`ld=1`).

## Configuration
- `FIFO_WR_ARB_LOCK_EN` defined: packet lock is enabled.
  - Two-state FSM: IDLE and LOCK(i).
  - In IDLE, an accept from g with `s_last[g]=0` goes to LOCK(g).
  - In LOCK(i), only requester i can be granted; other `s_valid` bits are masked.
  - An accept from i with `s_last[i]=1` returns to IDLE.
  - `rr` updates only on IDLE transitions, i.e. on single-word packets or on the last word.
  - An accept with `s_last=1` in IDLE stays in IDLE.
- Macro undefined: no FSM, `locked` is constant 0, `s_last` is ignored, and every word is arbitrated independently.

## Structure
- Package `fifo_wr_arb_pkg` holds:
  - the `arb_state_t` enum {IDLE, LOCK};
  - a function `rr_pick(valid, ptr, n)` that returns the winner index and a found flag.
- One sub-module, `rr_arbiter`: combinational priority rotate plus the registered `rr` pointer, with parameter N.
- The top level contains the output stage, the handshake, and the optional FSM.
- Instantiated upstream of `fifo_behav`, with `fifo_wr_en` → `wr_en`, `fifo_din` → `din`, and `full` → `fifo_full`.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `s_valid=1111` → `s_ready=0000`, `fifo_wr_en=0`, `busy=0`. First accept after release goes to requester 0.
- **Round-robin:** N=4, all valid continuously, `fifo_full=0` → grants 0,1,2,3,0,… Writes appear one cycle later with tags 0,1,2,3 and matching data (e.g. `s_data[i]=16'hA0+i`).
- **Full backpressure:** stage holds tag 2 / data `0x1234`, raise `fifo_full` for 5 cycles → `fifo_wr_en=0`, `s_ready=0`, `fifo_din` stable. When full drops, `0x1234` is written that cycle and the next winner is accepted in the same cycle.
- **Sparse / wrap:** only requesters 3 and 1 valid, `rr=2` → grant 3, then 1, then 3. With N=3, a grant to 2 wraps `rr` to 0.
- **Lock (macro defined):** requester 1 sends 3 words with `s_last=0,0,1` while requester 0 is valid → FIFO receives 1,1,1 then 0. Without the macro → 1,0,1,0 interleaved.
- **Reset mid-packet:** assert `rst` while in LOCK(2) with `ov=1` → next cycle `ov=0`, lock cleared, and arbitration restarts at 0.
